// File: rtl/imem_pkg.sv
// Shared definitions for the instruction memory and its loader.
// Also home of the address-window check reused by the data memory.
package imem_pkg;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } load_state_e;

    // True when addr is word aligned and lies inside [base, base+span_bytes).
    function automatic logic addr_in_window(
        input logic [31:0] addr,
        input logic [31:0] base,
        input logic [31:0] span_bytes
    );
        logic [31:0] off;
        off = addr - base;
        return (addr[1:0] == 2'b00) && (off < span_bytes);
    endfunction

endpackage

// File: rtl/imem_ram.sv
// Simple dual-port RAM: one write port, one registered read port.
// The array has no reset so it maps onto block RAM.
module imem_ram #(
    parameter int XLEN        = 32,
    parameter int DEPTH_WORDS = 1024,
    localparam int AW         = $clog2(DEPTH_WORDS)
) (
    input  logic            clk,
    input  logic            we_i,
    input  logic [AW-1:0]   waddr_i,
    input  logic [XLEN-1:0] wdata_i,
    input  logic            re_i,
    input  logic [AW-1:0]   raddr_i,
    output logic [XLEN-1:0] rdata_o
);

    logic [XLEN-1:0] mem_q [DEPTH_WORDS];
    logic [XLEN-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/imem_loadable.sv
// Instruction memory with a one-cycle fetch port and a streaming image loader.
// Fetches are only served while the loader is idle.
//
//   state | meaning
//   IDLE  | fetch port open, waiting for load_start
//   LOAD  | accepting image words, fetches refused
//   DONE  | one-cycle load_done pulse, then back to IDLE
module imem_loadable
    import imem_pkg::*;
#(
    parameter int              XLEN        = 32,
    parameter int              DEPTH_WORDS = 1024,
    parameter logic [XLEN-1:0] BASE_ADDR   = '0,
    localparam int             AW          = $clog2(DEPTH_WORDS),
    localparam int             CW          = AW + 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            fetch_req,
    input  logic [XLEN-1:0] fetch_addr,
    output logic            fetch_ready,
    output logic            fetch_valid,
    output logic [XLEN-1:0] fetch_data,
    output logic            fetch_fault,
    input  logic            load_start,
    input  logic [XLEN-1:0] load_base,
    input  logic            load_valid,
    input  logic [XLEN-1:0] load_data,
    input  logic            load_last,
    output logic            load_ready,
    output logic            load_busy,
    output logic            load_done,
    output logic            load_overflow,
    output logic [CW-1:0]   load_count
);

    load_state_e     state_q, state_d;
    logic [XLEN-1:0] ptr_q, ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            ovf_q, ovf_d;
    logic            base_mis_q, base_mis_d;
    logic            fetch_valid_q, fetch_fault_q, nop_sel_q;

    logic            fetch_accept, fetch_bad;
    logic            load_hs, wr_drop, ram_we, ram_re;
    logic [AW-1:0]   ram_raddr, ram_waddr;
    logic [XLEN-1:0] ram_rdata;

    assign fetch_accept = fetch_req && fetch_ready;
    assign fetch_bad    = !addr_in_window(fetch_addr, BASE_ADDR, 32'(DEPTH_WORDS * 4));
    assign ram_raddr    = AW'((fetch_addr - BASE_ADDR) >> 2);
    assign ram_re       = fetch_accept && !fetch_bad;

    assign load_hs   = load_valid && load_ready;
    assign wr_drop   = base_mis_q || (ptr_q >= XLEN'(DEPTH_WORDS));
    assign ram_we    = load_hs && !wr_drop && !reset;
    assign ram_waddr = AW'(ptr_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (load_start) state_d = LOAD;
            LOAD:    if (load_hs && load_last) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        fetch_ready = (state_q == IDLE);
        load_ready  = (state_q == LOAD);
        load_busy   = (state_q != IDLE);
        load_done   = (state_q == DONE);
    end

    // A misaligned base poisons the whole load; every word is dropped.
    always_comb begin
        ptr_d      = ptr_q;
        count_d    = count_q;
        ovf_d      = ovf_q;
        base_mis_d = base_mis_q;
        if ((state_q == IDLE) && load_start) begin
            ptr_d      = (load_base - BASE_ADDR) >> 2;
            count_d    = '0;
            ovf_d      = 1'b0;
            base_mis_d = (load_base[1:0] != 2'b00);
        end else if (load_hs) begin
            ptr_d = ptr_q + XLEN'(1);
            if (count_q != '1) begin
                count_d = count_q + CW'(1);
            end
            if (wr_drop) begin
                ovf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q      <= '0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
            base_mis_q <= 1'b0;
        end else begin
            ptr_q      <= ptr_d;
            count_q    <= count_d;
            ovf_q      <= ovf_d;
            base_mis_q <= base_mis_d;
        end
    end

    // nop_sel_q only moves on an accepted fetch so fetch_data holds between requests.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_valid_q <= 1'b0;
            fetch_fault_q <= 1'b0;
            nop_sel_q     <= 1'b1;
        end else begin
            fetch_valid_q <= fetch_accept;
            fetch_fault_q <= fetch_accept && fetch_bad;
            if (fetch_accept) begin
                nop_sel_q <= fetch_bad;
            end
        end
    end

    assign fetch_valid   = fetch_valid_q;
    assign fetch_fault   = fetch_fault_q;
    assign fetch_data    = nop_sel_q ? XLEN'(NOP) : ram_rdata;
    assign load_overflow = ovf_q;
    assign load_count    = count_q;

    imem_ram #(
        .XLEN        (XLEN),
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_ram (
        .clk     (clk),
        .we_i    (ram_we),
        .waddr_i (ram_waddr),
        .wdata_i (load_data),
        .re_i    (ram_re),
        .raddr_i (ram_raddr),
        .rdata_o (ram_rdata)
    );

endmodule

// File: doc/imem_loadable.md
# imem_loadable

Parametrised, synchronous-read instruction memory for the RV32 core's fetch stage, with an in-system streaming loader for program images. Replaces the combinational, reset-cleared instruction store with a RAM-inferable array, a one-cycle registered fetch port with alignment and range fault reporting, and a valid/ready load channel that writes consecutive words from a programmable base address. Sits between the fetch stage (read side) and the debug/boot loader (write side).

## Interface

Parameters:
- XLEN, 32, address and data width in bits
- DEPTH_WORDS, 1024, memory depth in 32-bit words; power of two, at least 4
- BASE_ADDR, 32'h0000_0000, byte address mapped to word 0; DEPTH_WORDS*4 aligned

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  reset, synchronous, active-high
- fetch_req  in  1  fetch request; accepted when fetch_ready is high
- fetch_addr  in  XLEN  byte address of the instruction, the PC
- fetch_ready  out  1  fetch port can accept a request
- fetch_valid  out  1  fetch_data/fetch_fault valid this cycle
- fetch_data  out  XLEN  fetched instruction word
- fetch_fault  out  1  accepted request was misaligned or out of range
- load_start  in  1  one-cycle pulse that begins a load
- load_base  in  XLEN  byte address of the first load word; sampled on load_start
- load_valid  in  1  load_data is valid
- load_data  in  XLEN  word to write
- load_last  in  1  qualifies the final word of the image
- load_ready  out  1  loader accepts a word this cycle
- load_busy  out  1  loader active
- load_done  out  1  one-cycle pulse after the last word is written
- load_overflow  out  1  sticky: a load word fell outside the array
- load_count  out  clog2(DEPTH_WORDS)+1  words accepted in the current or most recent load

## Operation

- Loader FSM states are IDLE, LOAD and DONE.
- IDLE to LOAD on load_start. The word pointer is set to (load_base - BASE_ADDR)>>2. load_count and load_overflow are cleared.
- LOAD:
  - load_ready=1.
  - Each load_valid&&load_ready handshake writes load_data at the pointer, increments the pointer and increments load_count (saturating).
  - A pointer at or above DEPTH_WORDS, or a misaligned load_base, drops the write and sets load_overflow.
  - A handshake with load_last moves the FSM to DONE.
- DONE: load_done=1 for one cycle, then IDLE.
- load_start outside IDLE is ignored. load_busy = (state != IDLE).
- fetch_ready = (state == IDLE). Fetches are refused during LOAD and DONE.
- A request is accepted on fetch_req&&fetch_ready.
- Fault when fetch_addr[1:0]!=0, or when fetch_addr-BASE_ADDR >= DEPTH_WORDS*4 (unsigned). A faulting fetch returns fetch_data = NOP (32'h0000_0013) and fetch_fault=1.
- Word index = (fetch_addr-BASE_ADDR)[clog2(DEPTH_WORDS)+1:2].
- Memory contents are not initialised or cleared by reset. Preload is only through the loader or a simulation $readmemh hook.

## Timing

- Reset values: fetch_valid=0, fetch_fault=0, fetch_data=NOP, load_ready=0, load_busy=0, load_done=0, load_overflow=0, load_count=0, FSM=IDLE. fetch_ready=1 in the first cycle after reset.
- Fetch latency is 1 cycle. A request accepted in cycle N gives fetch_valid=1 in N+1. Back-to-back requests give one result per cycle.
- Without an accepted request, fetch_valid=0 and fetch_data holds its last value.
- load_start and fetch_req in the same IDLE cycle:
  - The fetch is accepted and returns pre-load contents in the next cycle.
  - The FSM enters LOAD.
- A load write in cycle N is visible to a fetch accepted in cycle N+2 or later. Fetches are blocked until IDLE, so no read-during-write case exists.
- load_last on the first handshake gives LOAD, DONE, IDLE: load_done is high 2 cycles after load_start.
- Reset mid-load:
  - The FSM returns to IDLE next cycle.
  - Words already written remain.
  - load_done is not pulsed.
  - load_count and load_overflow are cleared.
- Reset with an outstanding fetch: fetch_valid=0 next cycle. The result is discarded.

## Structure

- Package imem_pkg holds:
  - the NOP constant 32'h0000_0013
  - the loader state enum (IDLE, LOAD, DONE)
  - a function computing the in-range/aligned check, shared with the data memory
- One sub-module, imem_ram: simple dual-port (1W, 1R) synchronous RAM, DEPTH_WORDS x XLEN. It has a registered read and no reset on the array, so it infers block RAM.
- The top level holds the FSM, pointer, counters, fault logic and output registers.

## Test plan

- Load 4 words 0x00500093, 0x00A00113, 0x002081B3, 0x0000006F from load_base=BASE_ADDR, last on word 4. Expect load_done 1 cycle after that handshake and load_count=4. Fetches to 0x0,0x4,0x8,0xC then return the same words, each with 1-cycle latency.
- Fetch 0x2 gives fetch_fault=1 and data 0x00000013. Fetch at DEPTH_WORDS*4 gives fetch_fault=1. Fetch at DEPTH_WORDS*4-4 gives no fault.
- Load from load_base=DEPTH_WORDS*4-4 with 3 words: word 1 is written, load_overflow=1, load_count=3, and the array is otherwise unchanged.
- Throttle load_valid on alternating cycles. Expect no dropped or duplicated writes, and fetch_ready=0 throughout the load.
- Assert reset after 2 of 5 load words: next cycle FSM is IDLE, load_done is never pulsed, load_count=0, and the first 2 words are readable.
- load_start and fetch_req to address 0x0 in the same cycle: the fetch returns old data in the next cycle, then the load proceeds normally.
